arc4_prga: RTL and testbench

//  ARC4 pseudo-random generation + decrypt stage; sits directly downstream of the key-schedule

---
 rtl/arc4_pkg.sv | 20 ++
 rtl/arc4_prga.sv | 145 ++++++++++++++
 tb/tb_arc4_prga.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: S-box geometry and the PRGA/decrypt state encoding.
package arc4_pkg;

  localparam int unsigned S_DEPTH = 256;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_LEN,
    ST_WR_LEN,
    ST_RDI,
    ST_LATI,
    ST_LATJ,
    ST_WRI,
    ST_RDP,
    ST_LATP,
    ST_DONE
  } prga_state_t;

endpackage

// File: rtl/arc4_prga.sv
// ARC4 PRGA + decrypt: reads length-prefixed ciphertext, swaps S in place and
// writes the length-prefixed plaintext; one FSM state per clock.
module arc4_prga
  import arc4_pkg::*;
#(
  parameter int unsigned MSG_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  output logic [7:0]        s_addr,
  input  logic [7:0]        s_rddata,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  output logic [MSG_AW-1:0] ct_addr,
  input  logic [7:0]        ct_rddata,
  output logic [MSG_AW-1:0] pt_addr,
  output logic [7:0]        pt_wrdata,
  output logic              pt_wren
);

  prga_state_t       state_q, state_d;
  logic [7:0]        i_q, i_d;
  logic [7:0]        j_q, j_d;
  logic [7:0]        si_q, si_d;
  logic [7:0]        sj_q, sj_d;
  logic [MSG_AW-1:0] k_q, k_d;
  logic [MSG_AW-1:0] len_q, len_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      k_q     <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      k_q     <= k_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    sj_d      = sj_q;
    k_d       = k_q;
    len_d     = len_q;
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          state_d = ST_RD_LEN;
          i_d     = '0;
          j_d     = '0;
          k_d     = MSG_AW'(1);
        end
      end
      ST_RD_LEN: begin
        ct_addr = '0;
        state_d = ST_WR_LEN;
      end
      ST_WR_LEN: begin
        len_d     = MSG_AW'(ct_rddata);
        pt_addr   = '0;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        if (len_d == '0) begin
          state_d = ST_DONE;
        end else begin
          i_d     = 8'd1;
          state_d = ST_RDI;
        end
      end
      ST_RDI: begin
        s_addr  = i_q;
        state_d = ST_LATI;
      end
      // j is advanced here so the S[j] read issues before either swap write,
      // which makes i==j read the pre-swap value.
      ST_LATI: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata;
        s_addr  = j_d;
        state_d = ST_LATJ;
      end
      ST_LATJ: begin
        sj_d     = s_rddata;
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = ST_WRI;
      end
      ST_WRI: begin
        s_addr   = i_q;
        s_wrdata = sj_q;
        s_wren   = 1'b1;
        state_d  = ST_RDP;
      end
      ST_RDP: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q;
        state_d = ST_LATP;
      end
      ST_LATP: begin
        pt_addr   = k_q;
        pt_wrdata = s_rddata ^ ct_rddata;
        pt_wren   = 1'b1;
        if (k_q == len_q) begin
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + MSG_AW'(1);
          i_d     = i_q + 8'd1;
          state_d = ST_RDI;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_arc4_prga.sv
// Directed bench for arc4_prga: sync-RAM models for S/CT/PT and hand-computed vectors.
module tb_arc4_prga;

  localparam int unsigned MSG_AW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              rdy;
  logic [7:0]        s_addr;
  logic [7:0]        s_rddata = '0;
  logic [7:0]        s_wrdata;
  logic              s_wren;
  logic [MSG_AW-1:0] ct_addr;
  logic [7:0]        ct_rddata = '0;
  logic [MSG_AW-1:0] pt_addr;
  logic [7:0]        pt_wrdata;
  logic              pt_wren;

  always #5 clk = ~clk;

  arc4_prga #(.MSG_AW(MSG_AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rdy      (rdy),
    .s_addr   (s_addr),
    .s_rddata (s_rddata),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren),
    .ct_addr  (ct_addr),
    .ct_rddata(ct_rddata),
    .pt_addr  (pt_addr),
    .pt_wrdata(pt_wrdata),
    .pt_wren  (pt_wren)
  );

  logic [7:0]  s_mem  [256];
  logic [7:0]  ct_mem [256];
  logic [7:0]  pt_mem [256];
  int unsigned s_wr_cnt  = 0;
  int unsigned pt_wr_cnt = 0;

  always @(posedge clk) begin
    if (s_wren) begin
      s_mem[s_addr] <= s_wrdata;
      s_wr_cnt      <= s_wr_cnt + 1;
    end
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (pt_wren) begin
      pt_mem[pt_addr] <= pt_wrdata;
      pt_wr_cnt       <= pt_wr_cnt + 1;
    end
  end

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  task automatic load_identity();
    for (int i = 0; i < 256; i++) s_mem[i] = 8'(i);
  endtask

  // Reference key schedule for key "Key" (0x4B 0x65 0x79).
  task automatic load_ksa();
    logic [7:0] key [3];
    logic [7:0] j;
    logic [7:0] t;
    key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
    load_identity();
    j = '0;
    for (int i = 0; i < 256; i++) begin
      j = j + s_mem[i] + key[i % 3];
      t = s_mem[i]; s_mem[i] = s_mem[j]; s_mem[j] = t;
    end
  endtask

  task automatic clear_pt();
    for (int i = 0; i < 256; i++) pt_mem[i] = 8'hAA;
  endtask

  task automatic run(input bit pulse_en, output int unsigned lat,
                     output int unsigned sw, output int unsigned pw);
    int unsigned s0;
    int unsigned p0;
    bit done;
    @(negedge clk);
    s0 = s_wr_cnt; p0 = pt_wr_cnt;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    lat = 0; done = 1'b0;
    while (!done) begin
      if (rdy) begin
        done = 1'b1;
      end else begin
        lat++;
        if (pulse_en) en = ~en;
        if (lat > 4000) begin
          check("rdy_timeout", {31'd0, rdy}, 32'd1);
          done = 1'b1;
        end
      end
      if (!done) @(negedge clk);
    end
    en = 1'b0;
    sw = s_wr_cnt - s0;
    pw = pt_wr_cnt - p0;
  endtask

  logic [7:0]  key_ct [10];
  logic [7:0]  key_pt [10];
  int unsigned lat, sw, pw, s0, p0;

  task automatic load_key_msg();
    for (int i = 0; i < 10; i++) ct_mem[i] = key_ct[i];
  endtask

  task automatic check_key_pt(input string tag);
    for (int i = 0; i < 10; i++) check($sformatf("%s_pt%0d", tag, i), {24'd0, pt_mem[i]}, {24'd0, key_pt[i]});
  endtask

  initial begin
    key_ct = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    key_pt = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    for (int i = 0; i < 256; i++) ct_mem[i] = '0;
    clear_pt();
    load_identity();
    rst = 1'b1; en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rdy",       {31'd0, rdy},     32'd1);
    check("rst_s_wren",    {31'd0, s_wren},  32'd0);
    check("rst_pt_wren",   {31'd0, pt_wren}, 32'd0);
    check("rst_s_addr",    {24'd0, s_addr},  32'd0);
    check("rst_ct_addr",   {24'd0, ct_addr}, 32'd0);
    check("rst_pt_wrdata", {24'd0, pt_wrdata}, 32'd0);
    en = 1'b0; rst = 1'b0;

    // L = 0: only the length byte is copied.
    ct_mem[0] = 8'h00;
    run(1'b0, lat, sw, pw);
    check("l0_lat", lat, 32'd3);
    check("l0_pt0", {24'd0, pt_mem[0]}, 32'h00);
    check("l0_swr", sw, 32'd0);
    check("l0_pwr", pw, 32'd1);
    check("l0_pt1", {24'd0, pt_mem[1]}, 32'hAA);

    // L = 1, identity S: i=j=1, pad S[2]=2.
    load_identity(); clear_pt();
    ct_mem[0] = 8'h01; ct_mem[1] = 8'hFF;
    run(1'b0, lat, sw, pw);
    check("l1_lat", lat, 32'd9);
    check("l1_pt0", {24'd0, pt_mem[0]}, 32'h01);
    check("l1_pt1", {24'd0, pt_mem[1]}, 32'hFD);
    check("l1_swr", sw, 32'd2);
    check("l1_s1",  {24'd0, s_mem[1]}, 32'h01);

    // L = 2, identity S: second byte swaps S[2]/S[3], pad S[5]=5.
    load_identity(); clear_pt();
    ct_mem[0] = 8'h02; ct_mem[1] = 8'hFF; ct_mem[2] = 8'h00;
    run(1'b0, lat, sw, pw);
    check("l2_lat", lat, 32'd15);
    check("l2_pt1", {24'd0, pt_mem[1]}, 32'hFD);
    check("l2_pt2", {24'd0, pt_mem[2]}, 32'h05);
    check("l2_s2",  {24'd0, s_mem[2]}, 32'h03);
    check("l2_s3",  {24'd0, s_mem[3]}, 32'h02);
    check("l2_pwr", pw, 32'd3);

    // Same message with en toggling throughout the busy window.
    load_identity(); clear_pt();
    run(1'b1, lat, sw, pw);
    check("pulse_lat", lat, 32'd15);
    check("pulse_pt2", {24'd0, pt_mem[2]}, 32'h05);
    check("pulse_swr", sw, 32'd4);
    check("pulse_pwr", pw, 32'd3);
    check("pulse_s2",  {24'd0, s_mem[2]}, 32'h03);

    // Known-answer vector: key "Key", plaintext "Plaintext".
    load_ksa(); clear_pt(); load_key_msg();
    run(1'b0, lat, sw, pw);
    check("key_lat", lat, 32'd57);
    check("key_swr", sw, 32'd18);
    check_key_pt("key");

    // Abort in LATJ of byte 3 (17th cycle after the accepting edge).
    load_ksa(); clear_pt();
    @(negedge clk);
    p0 = pt_wr_cnt;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (16) @(negedge clk);
    check("abort_latj_swren", {31'd0, s_wren}, 32'd1);
    check("abort_latj_rdy",   {31'd0, rdy},    32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_rdy",     {31'd0, rdy},     32'd1);
    check("abort_s_wren",  {31'd0, s_wren},  32'd0);
    check("abort_pt_wren", {31'd0, pt_wren}, 32'd0);
    check("abort_pwr",     pt_wr_cnt - p0,   32'd3);
    s0 = s_wr_cnt; p0 = pt_wr_cnt;
    repeat (6) @(negedge clk);
    check("abort_idle_swr", s_wr_cnt - s0,  32'd0);
    check("abort_idle_pwr", pt_wr_cnt - p0, 32'd0);
    check("abort_pt1",      {24'd0, pt_mem[1]}, 32'h50);
    check("abort_pt3",      {24'd0, pt_mem[3]}, 32'hAA);

    load_ksa(); clear_pt();
    run(1'b0, lat, sw, pw);
    check("rerun_lat", lat, 32'd57);
    check_key_pt("rerun");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
